// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: circular buffer, registered read port,
// occupancy/full/empty status and a sticky overflow flag for dropped bytes.
module uart_rx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_rd_en,
  input  logic                  i_clr_overflow,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  full, empty, wr_acc, rd_acc;

  assign full  = (count_q == CNT_WIDTH'(DEPTH));
  assign empty = (count_q == '0);

  // A full FIFO still takes a write when a read frees the slot on the same edge.
  assign rd_acc = i_rd_en && !empty;
  assign wr_acc = i_rx_valid && (!full || i_rd_en);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
      rd_data_d  = mem_q[rd_ptr_q];
      rd_valid_d = 1'b1;
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase

    // Set has priority over clear.
    if (i_clr_overflow) overflow_d = 1'b0;
    if (i_rx_valid && full && !i_rd_en) overflow_d = 1'b1;
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is not reset; contents are don't-care after reset.
  always_ff @(posedge sysclk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= i_rx_data;
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_count    = count_q;
  assign o_overflow = overflow_q;
  assign o_empty    = empty;
  assign o_full     = full;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_uart_rx_fifo;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          sysclk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] i_rx_data = '0;
  logic          i_rx_valid = 1'b0;
  logic          i_rd_en = 1'b0;
  logic          i_clr_overflow = 1'b0;
  logic [DW-1:0] o_rd_data;
  logic          o_rd_valid, o_empty, o_full, o_overflow;
  logic [AW:0]   o_count;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  logic       exp_ovf = 1'b0;
  logic       exp_vld = 1'b0;
  logic [7:0] exp_data = 8'h00;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .sysclk(sysclk), .rst(rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_rd_en(i_rd_en), .i_clr_overflow(i_clr_overflow), .o_rd_data(o_rd_data),
    .o_rd_valid(o_rd_valid), .o_empty(o_empty), .o_full(o_full), .o_count(o_count),
    .o_overflow(o_overflow)
  );

  always #4 sysclk = ~sysclk;

  // Drive one cycle of inputs and advance the reference model across that edge.
  task automatic step(input logic v, input logic [7:0] d, input logic rd, input logic clr);
    bit full, empty, rd_acc, wr_acc;
    i_rx_valid = v; i_rx_data = d; i_rd_en = rd; i_clr_overflow = clr;
    @(posedge sysclk);
    full   = (q.size() == DEPTH);
    empty  = (q.size() == 0);
    rd_acc = rd && !empty;
    wr_acc = v && (!full || rd);
    exp_vld = rd_acc;
    if (rd_acc) exp_data = q.pop_front();
    if (wr_acc) q.push_back(d);
    if (v && full && !rd) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    #1;
    i_rx_valid = 1'b0; i_rd_en = 1'b0; i_clr_overflow = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    exp_ovf = 1'b0; exp_vld = 1'b0; exp_data = 8'h00;
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({o_count, o_empty, o_full, o_rd_valid, o_overflow} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state: got cnt=%0d e=%b f=%b v=%b o=%b required cnt=0 e=1 f=0 v=0 o=0",
               o_count, o_empty, o_full, o_rd_valid, o_overflow);
    end
    tests++;
    if (o_rd_data !== 8'h00) begin
      fails++; $display("FAIL reset_rd_data: got %h required 00", o_rd_data);
    end
    @(posedge sysclk); #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'h20, 1'b1, 1'b0);
    tests++;
    if (o_count !== 5'd5) begin
      fails++; $display("FAIL pre_reset_count: got %0d required 5", o_count);
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    tests++;
    if ({o_count, o_empty, o_rd_valid, o_overflow} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midcycle_reset: got cnt=%0d e=%b v=%b o=%b required cnt=0 e=1 v=0 o=0",
               o_count, o_empty, o_rd_valid, o_overflow);
    end
    @(posedge sysclk); #1 rst = 1'b0;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== 8'hA5) begin
      fails++; $display("FAIL post_reset_read: got v=%b d=%h required v=1 d=a5", o_rd_valid, o_rd_data);
    end
  endtask

  task automatic test_order();
    logic [7:0] bytes [3];
    bytes[0] = 8'h0B; bytes[1] = 8'h3C; bytes[2] = 8'hFF;
    for (int i = 0; i < 3; i++) step(1'b1, bytes[i], 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      tests++;
      if (o_rd_valid !== 1'b1 || o_rd_data !== bytes[i] || exp_data !== bytes[i]) begin
        fails++; $display("FAIL order_read%0d: got v=%b d=%h required v=1 d=%h", i, o_rd_valid, o_rd_data, bytes[i]);
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    tests++;
    if (o_empty !== 1'b1 || o_count !== 5'd0 || o_rd_valid !== 1'b0 || o_rd_data !== 8'hFF) begin
      fails++;
      $display("FAIL order_idle: got e=%b cnt=%0d v=%b d=%h required e=1 cnt=0 v=0 d=ff",
               o_empty, o_count, o_rd_valid, o_rd_data);
    end
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    tests++;
    if (o_full !== 1'b1 || o_count !== 5'd16 || o_empty !== 1'b0) begin
      fails++; $display("FAIL full_flag: got f=%b cnt=%0d e=%b required f=1 cnt=16 e=0", o_full, o_count, o_empty);
    end
    step(1'b1, 8'h55, 1'b0, 1'b0);
    tests++;
    if (o_overflow !== 1'b1 || o_count !== 5'd16) begin
      fails++; $display("FAIL overflow_set: got o=%b cnt=%0d required o=1 cnt=16", o_overflow, o_count);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      tests++;
      if (o_rd_valid !== 1'b1 || o_rd_data !== 8'(i)) begin
        fails++; $display("FAIL drain_full%0d: got v=%b d=%h required v=1 d=%h", i, o_rd_valid, o_rd_data, 8'(i));
      end
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (o_rd_valid !== 1'b0 || o_empty !== 1'b1 || o_overflow !== 1'b1) begin
      fails++; $display("FAIL no_0x55: got v=%b e=%b o=%b required v=0 e=1 o=1", o_rd_valid, o_empty, o_overflow);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    tests++;
    if (o_overflow !== 1'b0) begin
      fails++; $display("FAIL overflow_clear: got %b required 0", o_overflow);
    end
  endtask

  task automatic test_full_rdwr();
    logic [7:0] last;
    last = 8'h00;
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    tests++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== 8'h00 || o_count !== 5'd16 || o_overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_rdwr: got v=%b d=%h cnt=%0d o=%b required v=1 d=00 cnt=16 o=0",
               o_rd_valid, o_rd_data, o_count, o_overflow);
    end
    while (q.size() != 0) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      tests++;
      if (o_rd_valid !== 1'b1 || o_rd_data !== exp_data) begin
        fails++; $display("FAIL full_rdwr_drain: got v=%b d=%h required v=1 d=%h", o_rd_valid, o_rd_data, exp_data);
      end
      last = o_rd_data;
    end
    tests++;
    if (last !== 8'h77) begin
      fails++; $display("FAIL full_rdwr_last: got %h required 77", last);
    end
  endtask

  task automatic test_empty();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (o_rd_valid !== 1'b0 || o_count !== 5'd0) begin
      fails++; $display("FAIL empty_read: got v=%b cnt=%0d required v=0 cnt=0", o_rd_valid, o_count);
    end
    step(1'b1, 8'h42, 1'b1, 1'b0);
    tests++;
    if (o_rd_valid !== 1'b0 || o_count !== 5'd1) begin
      fails++; $display("FAIL empty_rdwr: got v=%b cnt=%0d required v=0 cnt=1", o_rd_valid, o_count);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    tests++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== 8'h42) begin
      fails++; $display("FAIL empty_next_read: got v=%b d=%h required v=1 d=42", o_rd_valid, o_rd_data);
    end
  endtask

  task automatic test_random_wrap();
    int writes;
    logic v, rd;
    writes = 0;
    for (int c = 0; c < 120; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 3) != 0);
      if (v && (q.size() < DEPTH || rd)) writes++;
      step(v, 8'($urandom), rd, 1'b0);
      tests++;
      if (o_rd_valid !== exp_vld || (exp_vld && o_rd_data !== exp_data) || o_count !== 5'(q.size()) ||
          o_empty !== (q.size() == 0) || o_full !== (q.size() == DEPTH) || o_overflow !== exp_ovf) begin
        fails++;
        $display("FAIL random_c%0d: got v=%b d=%h cnt=%0d e=%b f=%b o=%b required v=%b d=%h cnt=%0d o=%b",
                 c, o_rd_valid, o_rd_data, o_count, o_empty, o_full, o_overflow,
                 exp_vld, exp_data, q.size(), exp_ovf);
      end
    end
    tests++;
    if (writes < 2 * DEPTH) begin
      fails++; $display("FAIL random_wrap_count: got %0d writes required >= %0d", writes, 2 * DEPTH);
    end
  endtask

  task automatic test_clr_overflow();
    while (q.size() < DEPTH) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    tests++;
    if (o_overflow !== 1'b1 || o_count !== 5'd16) begin
      fails++; $display("FAIL clr_vs_set: got o=%b cnt=%0d required o=1 cnt=16", o_overflow, o_count);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    tests++;
    if (o_overflow !== 1'b0) begin
      fails++; $display("FAIL clr_alone: got %b required 0", o_overflow);
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_full_overflow();
    test_full_rdwr();
    test_empty();
    test_random_wrap();
    test_clr_overflow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
